alu_operand_loader: RTL and testbench



---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_operand_loader_btn_debounce.sv | 58 +++++
 rtl/alu_operand_loader.sv | 114 +++++++++++
 tb/tb_alu_operand_loader.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU front end: loader FSM state encodings,
// opcode width and the ALU opcode values used by the ALU and its bench.
package alu_pkg;

    localparam int OPCODE_W = 6;

    typedef enum logic [1:0] {
        WAIT_A  = 2'd0,
        WAIT_B  = 2'd1,
        WAIT_OP = 2'd2,
        READY   = 2'd3
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_ADD = 6'b100000;
    localparam logic [OPCODE_W-1:0] OP_SUB = 6'b100010;
    localparam logic [OPCODE_W-1:0] OP_AND = 6'b100100;
    localparam logic [OPCODE_W-1:0] OP_OR  = 6'b100101;
    localparam logic [OPCODE_W-1:0] OP_XOR = 6'b100110;
    localparam logic [OPCODE_W-1:0] OP_SRA = 6'b000011;
    localparam logic [OPCODE_W-1:0] OP_SRL = 6'b000010;
    localparam logic [OPCODE_W-1:0] OP_NOR = 6'b100111;

endpackage

// File: rtl/alu_operand_loader_btn_debounce.sv
// Push-button conditioning: two-flop synchroniser, counter-based debouncer
// and a single-cycle pulse on each accepted press (releases give no pulse).
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic             level;
    logic [CNT_W-1:0] cnt;
    logic             differ;
    logic             expire;

    assign differ = (sync_2 != level);
    assign expire = differ && (cnt == CNT_MAX);

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= i_btn;
            sync_2 <= sync_1;
        end
    end

    // Accept a new level only after it has been seen unchanged for the full
    // window; the pulse is raised on the same edge the level flips to 1, so
    // the consumer acts one edge later.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt     <= '0;
            level   <= 1'b0;
            o_pulse <= 1'b0;
        end else begin
            o_pulse <= 1'b0;
            if (!differ) begin
                cnt <= '0;
            end else if (expire) begin
                cnt     <= '0;
                level   <= sync_2;
                o_pulse <= sync_2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/alu_operand_loader.sv
// ALU front end: captures operand A, operand B and the opcode from the shared
// switch bus in A -> B -> OP order, driven by three debounced push-buttons,
// and holds them on registered outputs with a valid flag.
module alu_operand_loader
    import alu_pkg::*;
#(
    parameter int SIZE            = 8,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [SIZE-1:0]     i_sw,
    input  logic                i_btn_a,
    input  logic                i_btn_b,
    input  logic                i_btn_op,
    output logic [SIZE-1:0]     o_a,
    output logic [SIZE-1:0]     o_b,
    output logic [OPCODE_W-1:0] o_opcode,
    output logic                o_valid,
    output logic [1:0]          o_state
);

    logic   pulse_a;
    logic   pulse_b;
    logic   pulse_op;
    state_t state;
    state_t state_next;
    logic   ld_a;
    logic   ld_b;
    logic   ld_op;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_btn   (i_btn_a),
        .o_pulse (pulse_a)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_btn   (i_btn_b),
        .o_pulse (pulse_b)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_op (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_btn   (i_btn_op),
        .o_pulse (pulse_op)
    );

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= WAIT_A;
        end else begin
            state <= state_next;
        end
    end

    // Next state: only the pulse legal in the current state advances; in
    // READY an A press restarts the sequence and takes priority over OP.
    always_comb begin
        state_next = state;
        unique case (state)
            WAIT_A:  if (pulse_a)  state_next = WAIT_B;
            WAIT_B:  if (pulse_b)  state_next = WAIT_OP;
            WAIT_OP: if (pulse_op) state_next = READY;
            READY:   if (pulse_a)  state_next = WAIT_B;
            default: state_next = WAIT_A;
        endcase
    end

    // Load enables for the capture registers, decoded from state and pulses.
    always_comb begin
        ld_a  = 1'b0;
        ld_b  = 1'b0;
        ld_op = 1'b0;
        unique case (state)
            WAIT_A:  ld_a  = pulse_a;
            WAIT_B:  ld_b  = pulse_b;
            WAIT_OP: ld_op = pulse_op;
            READY: begin
                ld_a  = pulse_a;
                ld_op = pulse_op && !pulse_a;
            end
            default: ;
        endcase
    end

    // Capture registers hold their value except on their own load edge;
    // a new A invalidates the operation, a new opcode completes it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_a      <= '0;
            o_b      <= '0;
            o_opcode <= '0;
            o_valid  <= 1'b0;
        end else begin
            if (ld_a)  o_a      <= i_sw;
            if (ld_b)  o_b      <= i_sw;
            if (ld_op) o_opcode <= i_sw[OPCODE_W-1:0];
            if (ld_a) begin
                o_valid <= 1'b0;
            end else if (ld_op) begin
                o_valid <= 1'b1;
            end
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader with a short debounce window:
// timed loads, a table of press/expected-result vectors, held and
// simultaneous buttons, and reset in the middle of a debounce.
module tb_alu_operand_loader;
    import alu_pkg::*;

    localparam int SIZE = 8;
    localparam int DEB  = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [SIZE-1:0] sw = '0;
    logic            btn_a = 1'b0;
    logic            btn_b = 1'b0;
    logic            btn_op = 1'b0;
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    logic [5:0]      opcode;
    logic            valid;
    logic [1:0]      st;

    int checks = 0;
    int errors = 0;

    alu_operand_loader #(.SIZE(SIZE), .DEBOUNCE_CYCLES(DEB)) dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .i_sw     (sw),
        .i_btn_a  (btn_a),
        .i_btn_b  (btn_b),
        .i_btn_op (btn_op),
        .o_a      (a),
        .o_b      (b),
        .o_opcode (opcode),
        .o_valid  (valid),
        .o_state  (st)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         btn;     // 0 = A, 1 = B, 2 = OP
        logic [7:0] sw;
        int         hold;
        logic [7:0] ea;
        logic [7:0] eb;
        logic [5:0] eop;
        logic       ev;
        logic [1:0] est;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                             input logic [5:0] eop, input logic ev, input logic [1:0] est);
        check({tag, ".a"},      32'(a),      32'(ea));
        check({tag, ".b"},      32'(b),      32'(eb));
        check({tag, ".opcode"}, 32'(opcode), 32'(eop));
        check({tag, ".valid"},  32'(valid),  32'(ev));
        check({tag, ".state"},  32'(st),     32'(est));
    endtask

    task automatic set_btn(input int sel, input logic v);
        case (sel)
            0: btn_a  = v;
            1: btn_b  = v;
            default: btn_op = v;
        endcase
    endtask

    // Hold a button for `hold` rising edges, then release for 10.
    task automatic press(input int sel, input logic [7:0] swv, input int hold);
        @(negedge clk);
        sw = swv;
        set_btn(sel, 1'b1);
        repeat (hold) @(negedge clk);
        set_btn(sel, 1'b0);
        repeat (10) @(negedge clk);
    endtask

    // Press with a latency check: nothing at edge k+DEB+1, load at k+DEB+2.
    task automatic timed_press(input string tag, input int sel, input logic [7:0] swv,
                               input logic [1:0] st_before, input logic [1:0] st_after);
        @(negedge clk);
        sw = swv;
        set_btn(sel, 1'b1);
        repeat (DEB + 2) @(posedge clk);
        @(negedge clk);
        check({tag, ".early_state"}, 32'(st), 32'(st_before));
        @(posedge clk);
        @(negedge clk);
        check({tag, ".load_state"}, 32'(st), 32'(st_after));
        repeat (3) @(negedge clk);
        set_btn(sel, 1'b0);
        repeat (10) @(negedge clk);
    endtask

    initial begin
        vecs[0]  = '{1, 8'hFF, 10, 8'h00, 8'h00, 6'h00, 1'b0, 2'd0};
        vecs[1]  = '{2, 8'hFF, 10, 8'h00, 8'h00, 6'h00, 1'b0, 2'd0};
        vecs[2]  = '{0, 8'h11,  3, 8'h00, 8'h00, 6'h00, 1'b0, 2'd0};
        vecs[3]  = '{0, 8'h11,  4, 8'h11, 8'h00, 6'h00, 1'b0, 2'd1};
        vecs[4]  = '{0, 8'h22, 10, 8'h11, 8'h00, 6'h00, 1'b0, 2'd1};
        vecs[5]  = '{2, 8'h3F, 10, 8'h11, 8'h00, 6'h00, 1'b0, 2'd1};
        vecs[6]  = '{1, 8'h03, 10, 8'h11, 8'h03, 6'h00, 1'b0, 2'd2};
        vecs[7]  = '{2, 8'h20, 10, 8'h11, 8'h03, OP_ADD, 1'b1, 2'd3};
        vecs[8]  = '{1, 8'h44, 10, 8'h11, 8'h03, OP_ADD, 1'b1, 2'd3};
        vecs[9]  = '{2, 8'h22, 10, 8'h11, 8'h03, OP_SUB, 1'b1, 2'd3};
        vecs[10] = '{0, 8'h80, 10, 8'h80, 8'h03, OP_SUB, 1'b0, 2'd1};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_all("reset", 8'h00, 8'h00, 6'h00, 1'b0, 2'd0);

        // Full load sequence with exact load latency.
        timed_press("load_a",  0, 8'h05, 2'd0, 2'd1);
        check("load_a.a", 32'(a), 32'h05);
        timed_press("load_b",  1, 8'h03, 2'd1, 2'd2);
        check("load_b.b", 32'(b), 32'h03);
        timed_press("load_op", 2, 8'h20, 2'd2, 2'd3);
        check_all("full_load", 8'h05, 8'h03, OP_ADD, 1'b1, 2'd3);

        // A and OP held together in READY: one A load only.
        @(negedge clk);
        sw = 8'h3C;
        btn_a = 1'b1;
        btn_op = 1'b1;
        repeat (25) @(negedge clk);
        sw = 8'h77;
        repeat (25) @(negedge clk);
        check_all("held_both", 8'h3C, 8'h03, OP_ADD, 1'b0, 2'd1);
        btn_a = 1'b0;
        btn_op = 1'b0;
        repeat (10) @(negedge clk);
        check_all("held_release", 8'h3C, 8'h03, OP_ADD, 1'b0, 2'd1);
        press(1, 8'h09, 10);
        check_all("after_held_b", 8'h3C, 8'h09, OP_ADD, 1'b0, 2'd2);

        // Reset while OP is being debounced in WAIT_OP.
        @(negedge clk);
        sw = 8'h2A;
        btn_op = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all("mid_reset", 8'h00, 8'h00, 6'h00, 1'b0, 2'd0);
        repeat (20) @(negedge clk);
        check_all("post_reset_hold", 8'h00, 8'h00, 6'h00, 1'b0, 2'd0);
        btn_op = 1'b0;
        repeat (10) @(negedge clk);

        // Vector table from WAIT_A: out-of-order, glitch, reload, restart.
        for (int i = 0; i < 11; i++) begin
            press(vecs[i].btn, vecs[i].sw, vecs[i].hold);
            check_all($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb,
                      vecs[i].eop, vecs[i].ev, vecs[i].est);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
